text_line_fetcher: RTL and testbench

//  Text-mode scheduler between the VGA timing Controller and the font ROM/text RAM.

---
 rtl/text_line_fetcher.sv | 256 +++++++++++++++++++++++++
 tb/tb_text_line_fetcher.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_fetcher.sv
// ----------------------------------------------------------------------------
// text_line_fetcher
//
// This block schedules text-mode reads between the VGA timing controller and
// the text RAM and font ROM. While one scan line is being displayed, it walks
// the COLS character cells of the *next* scan line. For each cell it reads the
// character code from text RAM, then reads the matching glyph row from the font
// ROM. The result goes into a back line buffer. At the end of each line the
// front and back buffers swap. The front buffer is shifted out one pixel per
// clock.
//
// Ports
//   CLK         25 MHz pixel clock
//   NRST        asynchronous active-low reset
//   PIXEL_CNTR  horizontal position, 0..H_TOTAL-1
//   ROW_NUM     vertical position
//   TEXT_RD     text RAM read strobe (data on TEXT_DATA one cycle later)
//   TEXT_ADDR   text RAM address = char_row*COLS + col
//   TEXT_DATA   character code from text RAM
//   FONT_RD     font ROM read strobe (data on FONT_DATA one cycle later)
//   CHAR_IN     character code presented to the font ROM
//   GLYPH_ROW   glyph row presented to the font ROM
//   FONT_DATA   glyph row bits, bit 7 is the leftmost pixel
//   PIXEL_OUT   registered pixel, one cycle behind PIXEL_CNTR
//   FETCH_BUSY  high while a line fetch is in progress
//   UNDERRUN    sticky flag: a swap happened before a fetch completed
// ----------------------------------------------------------------------------
module text_line_fetcher #(
    parameter int unsigned COLS     = 80,
    parameter int unsigned FONT_H   = 16,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [9:0]  PIXEL_CNTR,
    input  logic [9:0]  ROW_NUM,
    output logic        TEXT_RD,
    output logic [11:0] TEXT_ADDR,
    input  logic [7:0]  TEXT_DATA,
    output logic        FONT_RD,
    output logic [7:0]  CHAR_IN,
    output logic [3:0]  GLYPH_ROW,
    input  logic [7:0]  FONT_DATA,
    output logic        PIXEL_OUT,
    output logic        FETCH_BUSY,
    output logic        UNDERRUN
);

    localparam int unsigned GW = $clog2(FONT_H);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TEXT  = 3'd1,
        ST_GLYPH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [9:0]  fr_q, fr_d;
    logic        busy_q, busy_d;
    logic        text_rd_q, text_rd_d;
    logic [11:0] text_addr_q, text_addr_d;
    logic        font_rd_q, font_rd_d;
    logic [7:0]  char_in_q, char_in_d;
    logic [3:0]  glyph_row_q, glyph_row_d;
    logic        underrun_q, underrun_d;
    logic        front_sel_q, front_sel_d;
    logic        wr_pend_q, wr_pend_d;
    logic [6:0]  wr_col_q, wr_col_d;
    logic        pixel_q, pixel_d;

    logic [7:0]  buf0_q [0:COLS-1];
    logic [7:0]  buf1_q [0:COLS-1];

    logic [9:0]  fr_next_s;
    logic [7:0]  front_byte_s;
    logic        swap_s;

    // Text RAM address of a cell. The character row is the fetch row with
    // the glyph-row bits dropped.
    function automatic logic [11:0] text_addr_f(input logic [9:0] fr, input logic [6:0] col);
        return 12'(fr[9:GW]) * 12'(COLS) + 12'(col);
    endfunction

    // Fetch row: the next scan line. It wraps to 0 on the last visible row
    // and stays at 0 through vertical blanking.
    always_comb begin
        if (ROW_NUM >= 10'(V_ACTIVE - 1)) begin
            fr_next_s = 10'd0;
        end else begin
            fr_next_s = ROW_NUM + 10'd1;
        end
    end

    assign swap_s = (PIXEL_CNTR == 10'(H_TOTAL - 1));

    // Fetch sequencer next-state logic. The swap override comes last, so it
    // has priority over any state transition in the same cycle.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        fr_d        = fr_q;
        busy_d      = busy_q;
        text_rd_d   = 1'b0;
        text_addr_d = text_addr_q;
        font_rd_d   = 1'b0;
        char_in_d   = char_in_q;
        glyph_row_d = glyph_row_q;
        underrun_d  = underrun_q;
        front_sel_d = front_sel_q;
        wr_col_d    = wr_col_q;
        // Font data arrives one cycle after the strobe.
        wr_pend_d   = font_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (PIXEL_CNTR == 10'd0) begin
                    fr_d        = fr_next_s;
                    col_d       = 7'd0;
                    busy_d      = 1'b1;
                    text_rd_d   = 1'b1;
                    text_addr_d = text_addr_f(fr_next_s, 7'd0);
                    state_d     = ST_TEXT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TEXT: begin
                state_d = ST_GLYPH;
            end
            ST_GLYPH: begin
                char_in_d   = TEXT_DATA;
                glyph_row_d = fr_q[GW-1:0];
                font_rd_d   = 1'b1;
                wr_col_d    = col_q;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                if (col_q == 7'(COLS - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    col_d       = col_q + 7'd1;
                    text_rd_d   = 1'b1;
                    text_addr_d = text_addr_f(fr_q, col_q + 7'd1);
                    state_d     = ST_TEXT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (swap_s) begin
            front_sel_d = ~front_sel_q;
            if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
                underrun_d = 1'b1;
            end else begin
                underrun_d = underrun_q;
            end
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            text_rd_d = 1'b0;
            font_rd_d = 1'b0;
        end else begin
            front_sel_d = front_sel_q;
        end
    end

    // Pixel selection from the front buffer, outside the active area blanked.
    always_comb begin
        front_byte_s = 8'h00;
        pixel_d      = 1'b0;
        if ((PIXEL_CNTR < 10'(H_ACTIVE)) && (ROW_NUM < 10'(V_ACTIVE))) begin
            if (front_sel_q) begin
                front_byte_s = buf1_q[PIXEL_CNTR[9:3]];
            end else begin
                front_byte_s = buf0_q[PIXEL_CNTR[9:3]];
            end
            pixel_d = front_byte_s[3'd7 - PIXEL_CNTR[2:0]];
        end else begin
            pixel_d = 1'b0;
        end
    end

    // Sequencer, output and flag registers.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q     <= ST_IDLE;
            col_q       <= 7'd0;
            fr_q        <= 10'd0;
            busy_q      <= 1'b0;
            text_rd_q   <= 1'b0;
            text_addr_q <= 12'd0;
            font_rd_q   <= 1'b0;
            char_in_q   <= 8'h00;
            glyph_row_q <= 4'd0;
            underrun_q  <= 1'b0;
            front_sel_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_col_q    <= 7'd0;
            pixel_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            fr_q        <= fr_d;
            busy_q      <= busy_d;
            text_rd_q   <= text_rd_d;
            text_addr_q <= text_addr_d;
            font_rd_q   <= font_rd_d;
            char_in_q   <= char_in_d;
            glyph_row_q <= glyph_row_d;
            underrun_q  <= underrun_d;
            front_sel_q <= front_sel_d;
            wr_pend_q   <= wr_pend_d;
            wr_col_q    <= wr_col_d;
            pixel_q     <= pixel_d;
        end
    end

    // Line buffer storage. Glyph rows are written into whichever buffer is not
    // being displayed.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < int'(COLS); i++) begin
                buf0_q[i] <= 8'h00;
                buf1_q[i] <= 8'h00;
            end
        end else if (wr_pend_q) begin
            if (front_sel_q) begin
                buf0_q[wr_col_q] <= FONT_DATA;
            end else begin
                buf1_q[wr_col_q] <= FONT_DATA;
            end
        end else begin
            buf0_q[0] <= buf0_q[0];
        end
    end

    assign TEXT_RD    = text_rd_q;
    assign TEXT_ADDR  = text_addr_q;
    assign FONT_RD    = font_rd_q;
    assign CHAR_IN    = char_in_q;
    assign GLYPH_ROW  = glyph_row_q;
    assign PIXEL_OUT  = pixel_q;
    assign FETCH_BUSY = busy_q;
    assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_text_line_fetcher.sv
// ----------------------------------------------------------------------------
// Directed bench for text_line_fetcher. The bench drives the raster counters
// itself and models the text RAM and the font ROM with one-cycle read latency.
// It keeps a small model of the expected line contents.
// ----------------------------------------------------------------------------
module tb_text_line_fetcher;

    logic        CLK = 1'b0;
    logic        NRST = 1'b1;
    logic [9:0]  PIXEL_CNTR = 10'd0;
    logic [9:0]  ROW_NUM = 10'd0;
    logic        TEXT_RD;
    logic [11:0] TEXT_ADDR;
    logic [7:0]  TEXT_DATA = 8'h00;
    logic        FONT_RD;
    logic [7:0]  CHAR_IN;
    logic [3:0]  GLYPH_ROW;
    logic [7:0]  FONT_DATA = 8'h00;
    logic        PIXEL_OUT;
    logic        FETCH_BUSY;
    logic        UNDERRUN;

    int n_assert = 0;
    int n_fail   = 0;
    bit font_ones = 1'b0;

    logic [7:0] exp_front [0:79];
    logic [7:0] exp_back  [0:79];
    bit         front_ok;
    bit         back_ok;

    logic [7:0] got_pix;
    int         ones_cnt;
    logic [11:0] first_addr;
    logic [3:0]  first_glyph;

    text_line_fetcher dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .PIXEL_CNTR (PIXEL_CNTR),
        .ROW_NUM    (ROW_NUM),
        .TEXT_RD    (TEXT_RD),
        .TEXT_ADDR  (TEXT_ADDR),
        .TEXT_DATA  (TEXT_DATA),
        .FONT_RD    (FONT_RD),
        .CHAR_IN    (CHAR_IN),
        .GLYPH_ROW  (GLYPH_ROW),
        .FONT_DATA  (FONT_DATA),
        .PIXEL_OUT  (PIXEL_OUT),
        .FETCH_BUSY (FETCH_BUSY),
        .UNDERRUN   (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] text_fn(input int a);
        logic [11:0] av;
        av = 12'(a);
        if (av == 12'd0) return 8'h48;
        return av[7:0] ^ {av[11:8], 4'h3};
    endfunction

    function automatic logic [7:0] font_fn(input logic [7:0] c, input logic [3:0] r, input bit ones);
        if (ones) return 8'hFF;
        if (c == 8'h48 && r == 4'd1) return 8'hC3;
        return c ^ {r, ~r};
    endfunction

    // Text RAM and font ROM models, both with one-cycle read latency.
    always @(posedge CLK) begin
        if (TEXT_RD) TEXT_DATA <= text_fn(int'(TEXT_ADDR));
        if (FONT_RD) FONT_DATA <= font_fn(CHAR_IN, GLYPH_ROW, font_ones);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_line(input int row, input int pc_first, input int pc_last, input bit chk_fetch);
        int fr;
        int base;
        logic [7:0] b;
        logic exp_pix;
        bit t_exp;
        bit f_exp;
        fr = (row >= 479) ? 0 : row + 1;
        base = (fr / 16) * 80;
        ones_cnt = 0;
        for (int pc = pc_first; pc <= pc_last; pc++) begin
            if (pc == 0) begin
                for (int c = 0; c < 80; c++) begin
                    exp_back[c] = font_fn(text_fn(base + c), 4'(fr % 16), font_ones);
                end
                back_ok = (pc_last >= 240);
            end
            PIXEL_CNTR = 10'(pc);
            ROW_NUM    = 10'(row);
            @(posedge CLK);
            #1;
            if (pc < 8) got_pix[7 - pc] = PIXEL_OUT;
            if (PIXEL_OUT === 1'b1) ones_cnt++;
            if (pc == 0) first_addr = TEXT_ADDR;
            if (pc == 2) first_glyph = GLYPH_ROW;
            if (front_ok) begin
                b = exp_front[(pc < 640) ? pc / 8 : 0];
                exp_pix = (pc < 640 && row < 480) ? b[7 - (pc % 8)] : 1'b0;
                chk("pixel", 32'(PIXEL_OUT), 32'(exp_pix));
            end
            if (chk_fetch) begin
                t_exp = (pc % 3 == 0) && (pc <= 237);
                f_exp = (pc % 3 == 2) && (pc <= 239);
                chk("text_rd", 32'(TEXT_RD), 32'(t_exp));
                if (t_exp) chk("text_addr", 32'(TEXT_ADDR), 32'(base + pc / 3));
                chk("font_rd", 32'(FONT_RD), 32'(f_exp));
                if (f_exp) begin
                    chk("char_in", 32'(CHAR_IN), 32'(text_fn(base + (pc - 2) / 3)));
                    chk("glyph_row", 32'(GLYPH_ROW), 32'(fr % 16));
                end
                chk("fetch_busy", 32'(FETCH_BUSY), 32'(pc <= 239));
            end
            if (pc == 799) begin
                for (int c = 0; c < 80; c++) exp_front[c] = exp_back[c];
                front_ok = back_ok;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_text_rd"},   32'(TEXT_RD),    32'd0);
        chk({tag, "_text_addr"}, 32'(TEXT_ADDR),  32'd0);
        chk({tag, "_font_rd"},   32'(FONT_RD),    32'd0);
        chk({tag, "_char_in"},   32'(CHAR_IN),    32'd0);
        chk({tag, "_glyph_row"}, 32'(GLYPH_ROW),  32'd0);
        chk({tag, "_pixel"},     32'(PIXEL_OUT),  32'd0);
        chk({tag, "_busy"},      32'(FETCH_BUSY), 32'd0);
        chk({tag, "_underrun"},  32'(UNDERRUN),   32'd0);
    endtask

    initial begin
        for (int c = 0; c < 80; c++) begin
            exp_front[c] = 8'h00;
            exp_back[c]  = 8'h00;
        end
        front_ok = 1'b1;
        back_ok  = 1'b1;

        // Reset state
        #2 NRST = 1'b0;
        #2 chk_all_zero("reset");
        @(posedge CLK);
        #1 NRST = 1'b1;

        // Test 1: first line after reset fetches row 1 (addresses 0..79);
        // it displays the blank buffer.
        run_line(0, 0, 799, 1'b1);
        chk("t1_first_addr", 32'(first_addr), 32'd0);
        chk("t1_glyph", 32'(first_glyph), 32'd1);
        chk("t1_underrun", 32'(UNDERRUN), 32'd0);

        // Test 2: 'H' glyph row 1 = C3 appears on the next line
        run_line(1, 0, 799, 1'b1);
        chk("t2_pix0_7", 32'(got_pix), 32'h000000C3);

        // Test 3: row 15 fetches row 16, row 479 wraps to row 0
        run_line(15, 0, 799, 1'b1);
        chk("t3_r15_addr", 32'(first_addr), 32'd80);
        chk("t3_r15_glyph", 32'(first_glyph), 32'd0);
        run_line(479, 0, 799, 1'b1);
        chk("t3_r479_addr", 32'(first_addr), 32'd0);
        chk("t3_r479_glyph", 32'(first_glyph), 32'd0);

        // Test 4: an all-ones buffer is blanked outside the active area
        font_ones = 1'b1;
        run_line(480, 0, 799, 1'b1);
        run_line(481, 0, 799, 1'b1);
        chk("t4_vblank_ones", 32'(ones_cnt), 32'd0);
        font_ones = 1'b0;
        run_line(0, 0, 799, 1'b1);
        chk("t4_active_ones", 32'(ones_cnt), 32'd640);

        // Test 5: early swap during a fetch aborts it; UNDERRUN is sticky
        chk("t5_pre_underrun", 32'(UNDERRUN), 32'd0);
        run_line(1, 0, 49, 1'b1);
        PIXEL_CNTR = 10'd799;
        @(posedge CLK);
        #1;
        chk("t5_busy", 32'(FETCH_BUSY), 32'd0);
        chk("t5_text_rd", 32'(TEXT_RD), 32'd0);
        chk("t5_font_rd", 32'(FONT_RD), 32'd0);
        chk("t5_underrun", 32'(UNDERRUN), 32'd1);
        for (int c = 0; c < 80; c++) exp_front[c] = exp_back[c];
        front_ok = 1'b0;
        for (int r = 2; r <= 4; r++) begin
            run_line(r, 0, 799, 1'b1);
            chk("t5_sticky", 32'(UNDERRUN), 32'd1);
        end

        // Test 6: reset in the middle of a fetch (column 40)
        run_line(5, 0, 120, 1'b1);
        #2 NRST = 1'b0;
        #1 chk_all_zero("t6_async");
        PIXEL_CNTR = 10'd121;
        @(posedge CLK);
        @(posedge CLK);
        #1 NRST = 1'b1;
        for (int c = 0; c < 80; c++) begin
            exp_front[c] = 8'h00;
            exp_back[c]  = 8'h00;
        end
        front_ok = 1'b1;
        back_ok  = 1'b1;
        run_line(5, 121, 799, 1'b0);
        run_line(6, 0, 799, 1'b1);
        chk("t6_blank_line", 32'(ones_cnt), 32'd0);
        run_line(7, 0, 799, 1'b1);
        chk("t6_underrun", 32'(UNDERRUN), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
